e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multiply/divide unit for the E stage of the pipelined MIPS core; sits beside the ALU.
- Owns the HI/LO registers and sequences multi-cycle mult/div operations.
- Issues Busy so hazard control can stall later HI/LO-touching instructions in D.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5: cycles Busy stays high for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10: cycles Busy stays high for div/divu; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- A  input  32  rs operand
- B  input  32  rt operand
- MDUOp  input  4  operation code (shared def constants)
- Start  input  1  one-cycle pulse; launches the mult/div/madd op named by MDUOp
- Busy  output  1  high while an operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- MDUOut  output  32  combinational read data: HI when MDUOp = mfhi, LO when MDUOp = mflo, else 0

Behaviour:
- Reset: HI=0, LO=0, Busy=0, state IDLE, counter 0, pending regs 0. A reset mid-operation aborts the op; HI/LO do not take the pending result.
- States:
  - IDLE: Start with a mult-class MDUOp -> MUL; Start with a div-class MDUOp -> DIV.
  - MUL/DIV: the counter counts down. At count 1 -> IDLE and commit.
- Launch:
  - At the edge where Start=1 in IDLE, operands are latched and the full result is computed into pending {pHI,pLO}.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
- Timing:
  - Start sampled at edge E0. Busy=1 in cycles E0+1 through E0+N.
  - HI/LO are written at the edge closing cycle E0+N, so new values are visible with Busy=0 in cycle E0+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64 bits; {HI,LO} = product.
  - multu: unsigned 32x32 -> 64 bits; {HI,LO} = product.
  - div: LO = quotient truncated toward zero; HI = remainder, same sign as the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
- Divide by zero: still busy for DIV_CYCLES; HI/LO keep their old values.
- mthi/mtlo: when MDUOp = mthi (mtlo) and Busy=0 and state IDLE, HI (LO) takes A at the edge. Start is not required.
- Ignored inputs:
  - Start while Busy: ignored; the in-flight op continues.
  - mthi/mtlo while Busy: ignored.
  - Start with a non-launch MDUOp: ignored.
  - Hazard logic must never issue these cases; the bench flags them.
- MDUOut is purely combinational from current HI/LO. There is no forwarding of a pending result.
- Opcode values 11..15: treated as MDU_none.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - madd and maddu are launchable ops with MULT_CYCLES latency.
  - At launch, pending = {HI,LO} + A*B, signed or unsigned, modulo 2^64. The {HI,LO} addend is sampled at launch.
- Undefined: madd and maddu behave as MDU_none (no Busy, no state change).

Decomposition:
- Shared def header holds the MDU opcode constants:
  - MDU_none=0, MDU_mult=1, MDU_multu=2, MDU_div=3, MDU_divu=4
  - MDU_mfhi=5, MDU_mflo=6, MDU_mthi=7, MDU_mtlo=8
  - MDU_madd=9, MDU_maddu=10
- The header also holds the state encodings S_IDLE/S_MUL/S_DIV.
- One natural sub-module, e_mdu_calc: a combinational 64-bit result generator (mult/div/madd, divide-by-zero flag). e_mdu keeps the FSM, counter and registers.

Test Plan:
- Reset, then mthi A=0x12345678 and mtlo A=0x9ABCDEF0 -> next cycle HI=0x12345678, LO=0x9ABCDEF0; mfhi gives MDUOut=0x12345678.
- mult A=0xFFFFFFFF, B=2, Start at E0 -> Busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE in cycle E0+6. Repeat with multu -> HI=1, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> Busy for 10 cycles; HI/LO unchanged.
- Second Start and an mthi during Busy -> both ignored; the first op's result commits at the normal cycle.
- reset asserted at the 3rd Busy cycle of a div -> next cycle Busy=0, HI=LO=0; no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus gives no Busy and no change.

Source files
------------

// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_pkg
//  Purpose  : Shared definitions for the E-stage multiply/divide unit:
//             MDU opcode constants, FSM state encodings and opcode
//             classification helpers.
//  Options  : MDU_MADD_EN - when defined, madd/maddu are launchable ops.
//  Revision : 1.0 - initial release
// ============================================================================
package e_mdu_pkg;

    // MDU opcodes (shared with the decoder)
    localparam logic [3:0] MDU_none  = 4'd0;
    localparam logic [3:0] MDU_mult  = 4'd1;
    localparam logic [3:0] MDU_multu = 4'd2;
    localparam logic [3:0] MDU_div   = 4'd3;
    localparam logic [3:0] MDU_divu  = 4'd4;
    localparam logic [3:0] MDU_mfhi  = 4'd5;
    localparam logic [3:0] MDU_mflo  = 4'd6;
    localparam logic [3:0] MDU_mthi  = 4'd7;
    localparam logic [3:0] MDU_mtlo  = 4'd8;
    localparam logic [3:0] MDU_madd  = 4'd9;
    localparam logic [3:0] MDU_maddu = 4'd10;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    // Ops that launch with the multiply latency. madd/maddu join this
    // class only when the accumulate feature is built in; otherwise they
    // fall through as no-ops like opcodes 11..15.
    function automatic logic is_mul_launch(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MDU_mult) || (op == MDU_multu) ||
               (op == MDU_madd) || (op == MDU_maddu);
`else
        return (op == MDU_mult) || (op == MDU_multu);
`endif
    endfunction

    // Ops that launch with the divide latency.
    function automatic logic is_div_launch(input logic [3:0] op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage : e_mdu_pkg
`default_nettype wire

// File: rtl/e_mdu_calc.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_calc
//  Purpose  : Combinational 64-bit result generator for the MDU. Produces
//             {HI,LO} for mult/multu/div/divu/madd/maddu and flags a zero
//             divisor.
//  Ports    : op      [3:0]  in  MDU opcode
//             a, b    [31:0] in  rs / rt operands
//             hi, lo  [31:0] in  current HI/LO (madd accumulator addend)
//             result  [63:0] out {HI,LO} candidate
//             divzero        out divisor is zero
//  Options  : none (madd results are always formed; launch gating lives in
//             the package helpers, MDU_MADD_EN)
//  Revision : 1.0 - initial release
// ============================================================================
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        divzero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_den_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // 64x64 products of the extended operands keep the low 64 bits, which is
    // exactly the 32x32 signed/unsigned full product.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide is done on magnitudes and the signs re-applied:
    // quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1,
    // negated back to 0x80000000 with remainder 0.
    assign w_div_signed = (op == MDU_div);
    assign w_a_neg      = w_div_signed & a[31];
    assign w_b_neg      = w_div_signed & b[31];
    assign w_num        = w_a_neg ? (~a + 32'd1) : a;
    assign w_den        = w_b_neg ? (~b + 32'd1) : b;
    // Keep the divider well defined on a zero divisor; the result is
    // discarded in that case anyway.
    assign w_den_safe   = (b == 32'd0) ? 32'd1 : w_den;
    assign w_q_mag      = w_num / w_den_safe;
    assign w_r_mag      = w_num % w_den_safe;
    assign w_q          = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r          = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    assign divzero = (b == 32'd0);

    always_comb begin
        result = 64'd0;
        case (op)
            MDU_mult:  result = w_prod_s;
            MDU_multu: result = w_prod_u;
            MDU_div,
            MDU_divu:  result = {w_r, w_q};
            MDU_madd:  result = {hi, lo} + w_prod_s;
            MDU_maddu: result = {hi, lo} + w_prod_u;
            default:   result = 64'd0;
        endcase
    end

endmodule : e_mdu_calc
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu
//  Purpose  : E-stage multiply/divide unit. Owns HI/LO, sequences multi-cycle
//             mult/div (and optional madd) operations, reports Busy for
//             hazard stalling, and serves mfhi/mflo/mthi/mtlo.
//  Ports    : clk            in  rising-edge clock
//             reset          in  synchronous active-high reset
//             A, B   [31:0]  in  rs / rt operands
//             MDUOp  [3:0]   in  MDU opcode
//             Start          in  one-cycle launch pulse
//             Busy           out operation in flight (registered)
//             HI, LO [31:0]  out architectural HI/LO
//             MDUOut [31:0]  out combinational mfhi/mflo read data
//  Params   : MULT_CYCLES (1..15), DIV_CYCLES (1..15)
//  Options  : MDU_MADD_EN - enables madd/maddu as launchable ops
//  Revision : 1.0 - initial release
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam logic [3:0] c_mult_n = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_n  = 4'(DIV_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_phi;
    logic [31:0] r_plo;
    logic        r_pdz;

    logic [63:0] w_result;
    logic        w_divzero;

    e_mdu_calc u_calc (
        .op      (MDUOp),
        .a       (A),
        .b       (B),
        .hi      (r_hi),
        .lo      (r_lo),
        .result  (w_result),
        .divzero (w_divzero)
    );

    // The whole result is formed at launch and parked in the pending
    // registers; the counter only models latency. A reset before the
    // final count drops the pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_pdz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start && is_mul_launch(MDUOp)) begin
                        r_state <= S_MUL;
                        r_cnt   <= c_mult_n;
                        r_busy  <= 1'b1;
                        r_phi   <= w_result[63:32];
                        r_plo   <= w_result[31:0];
                        r_pdz   <= 1'b0;
                    end else if (Start && is_div_launch(MDUOp)) begin
                        r_state <= S_DIV;
                        r_cnt   <= c_div_n;
                        r_busy  <= 1'b1;
                        r_phi   <= w_result[63:32];
                        r_plo   <= w_result[31:0];
                        r_pdz   <= w_divzero;
                    end else if (MDUOp == MDU_mthi) begin
                        r_hi <= A;
                    end else if (MDUOp == MDU_mtlo) begin
                        r_lo <= A;
                    end
                end
                S_MUL, S_DIV: begin
                    // Start and mthi/mtlo are deliberately not looked at here.
                    if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        if (!r_pdz) begin
                            r_hi <= r_phi;
                            r_lo <= r_plo;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // No forwarding of the pending result: reads see committed HI/LO only.
    assign MDUOut = (MDUOp == MDU_mfhi) ? r_hi :
                    (MDUOp == MDU_mflo) ? r_lo : 32'd0;

endmodule : e_mdu
`default_nettype wire
